fetch_queue: RTL and testbench

Instruction queue between the fetch stage and decode. It buffers fetched (pc, instruction) pairs in a small circular FIFO, so fetch keeps running while decode stalls. A flush from branch resolution drops everything in flight. It presents entries to decode in strict program order over a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fq_storage.sv | 28 ++
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
package fetch_pkg;

    localparam int XLEN = 32;

    // Word that decode substitutes when it needs to insert a bubble (addi x0, x0, 0).
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one synchronous write port, one
// asynchronous read port. Contents are never reset; the pointer logic in
// the parent decides which slots hold live data.
import fetch_pkg::*;

module fq_storage #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fetch_entry_t             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fetch_entry_t             rdata
);

    fetch_entry_t mem [DEPTH];

    // Capture the incoming entry into its slot on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode. Wrap-bit pointers
// distinguish full from empty; flush empties the queue in one cycle and
// drops any entry offered alongside it.
import fetch_pkg::*;

module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = fetch_pkg::XLEN
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [XLEN-1:0]              in_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [XLEN-1:0]              out_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head_entry;

    // Same slot index: equal wrap bits mean empty, differing wrap bits mean full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

    // Handshake flags come from state only, so fetch and decode see no
    // combinational loop through the queue.
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push = in_valid && !full && !flush;
    assign pop  = out_ready && !empty && !flush;

    assign count = CNT_W'(wr_ptr - rd_ptr);

    // Pointer update: flush collapses both pointers to zero, otherwise
    // each side advances independently on its own handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    assign wr_entry.pc    = in_pc;
    assign wr_entry.instr = in_instr;

    fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[IDX_W-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[IDX_W-1:0]),
        .rdata (head_entry)
    );

    // Stale slot contents are masked so decode sees zeros while empty.
    assign out_pc    = empty ? '0 : head_entry.pc;
    assign out_instr = empty ? '0 : head_entry.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [2:0]      count;

    int vectors;
    int miscompares;

    logic [XLEN-1:0] model_pc[$];
    logic [XLEN-1:0] model_instr[$];

    fetch_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        int n;
        n = model_pc.size();
        compare({tag, ".in_ready"},  32'(in_ready),  32'(n < DEPTH));
        compare({tag, ".out_valid"}, 32'(out_valid), 32'(n > 0));
        compare({tag, ".out_pc"},    out_pc,         (n > 0) ? model_pc[0] : 32'h0);
        compare({tag, ".out_instr"}, out_instr,      (n > 0) ? model_instr[0] : 32'h0);
        compare({tag, ".count"},     32'(count),     32'(n));
    endtask

    task automatic modelClear();
        model_pc.delete();
        model_instr.delete();
    endtask

    // One clock cycle: drive inputs just after an edge, check before the next
    // edge, then advance the model by the queue's rules.
    task automatic applyStimulus(input string tag, input logic f, input logic iv,
                                 input logic [31:0] pc, input logic [31:0] instr,
                                 input logic ordy);
        int  n;
        bit  do_pop;
        bit  do_push;
        flush     = f;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = ordy;
        @(negedge clk);
        checkOutput(tag);
        n       = model_pc.size();
        do_pop  = !f && ordy && (n > 0);
        do_push = !f && iv && (n < DEPTH);
        @(posedge clk);
        if (f) begin
            modelClear();
        end else begin
            if (do_pop) begin
                void'(model_pc.pop_front());
                void'(model_instr.pop_front());
            end
            if (do_push) begin
                model_pc.push_back(pc);
                model_instr.push_back(instr);
            end
        end
        #1;
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus($sformatf("%s%0d", tag, i), 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_pc       = '0;
        in_instr    = '0;
        out_ready   = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Three pushes with decode stalled
        applyStimulus("push0", 1'b0, 1'b1, 32'd0, 32'h1111_1111, 1'b0);
        applyStimulus("push1", 1'b0, 1'b1, 32'd4, 32'h2222_2222, 1'b0);
        applyStimulus("push2", 1'b0, 1'b1, 32'd8, 32'h3333_3333, 1'b0);
        idle("hold3");
        compare("hold3.count_abs", 32'(count), 32'd3);
        compare("hold3.instr_abs", out_instr, 32'h1111_1111);

        // Fill, reject a fifth entry, pop once, refill, drain
        applyStimulus("fill3", 1'b0, 1'b1, 32'd12, 32'h4444_4444, 1'b0);
        applyStimulus("full_reject", 1'b0, 1'b1, 32'd16, 32'h5555_5555, 1'b0);
        compare("full.in_ready_abs", 32'(in_ready), 32'd0);
        applyStimulus("full_pop", 1'b0, 1'b1, 32'd16, 32'h5555_5555, 1'b1);
        applyStimulus("refill", 1'b0, 1'b1, 32'd16, 32'h5555_5555, 1'b0);
        compare("refill.head_abs", out_pc, 32'd4);
        drain("drainA");

        // Streaming with both handshakes held high
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("stream%0d", i), 1'b0, 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1);
        end
        compare("stream.count_abs", 32'(count), 32'd1);
        compare("stream.last_pc_abs", out_pc, 32'd36);
        drain("drainB");

        // Flush with an offered entry in the same cycle
        applyStimulus("fl_push0", 1'b0, 1'b1, 32'd8,  32'hB000_0008, 1'b0);
        applyStimulus("fl_push1", 1'b0, 1'b1, 32'd12, 32'hB000_000C, 1'b0);
        applyStimulus("fl_push2", 1'b0, 1'b1, 32'd16, 32'hB000_0010, 1'b0);
        applyStimulus("flush",    1'b1, 1'b1, 32'd20, 32'hB000_0014, 1'b1);
        applyStimulus("post_flush", 1'b0, 1'b1, 32'd24, 32'hB000_0018, 1'b0);
        idle("after_flush");
        compare("flush.head_abs", out_pc, 32'd24);
        drain("drainC");

        // Asynchronous reset in mid-stream with two entries stored
        applyStimulus("ar_push0", 1'b0, 1'b1, 32'd40, 32'hC000_0028, 1'b0);
        applyStimulus("ar_push1", 1'b0, 1'b1, 32'd44, 32'hC000_002C, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b1;
        modelClear();
        #2;
        checkOutput("async_reset");
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle("after_reset");

        // Simultaneous push and pop at count 1
        applyStimulus("pp_push", 1'b0, 1'b1, 32'd100, 32'hD000_0064, 1'b0);
        applyStimulus("pp_both", 1'b0, 1'b1, 32'd104, 32'hD000_0068, 1'b1);
        idle("pp_after");
        compare("pp.head_abs", out_pc, 32'd104);
        drain("drainD");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($sformatf("rand%0d", i),
                          ($urandom_range(0, 15) == 0),
                          1'($urandom),
                          $urandom, $urandom,
                          1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
